booth_final_stage: RTL and testbench

Second-level compression and final carry-propagate stage of the 16x16 radix-4 Booth multiplier. It consumes the six sum/carry rows produced by the first 3:2 compression layer. It reduces them to two rows, adds them, and delivers the 32-bit product. It is a 2-stage valid/ready pipeline between the compression layer and the multiplier result register.

---
 rtl/booth_final_stage.sv | 119 +++++++++++
 tb/tb_booth_final_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_final_stage.sv
`default_nettype none
// ============================================================================
// Module      : booth_final_stage
// Description : Second-level 3:2 compression and final carry-propagate add
//               for the 16x16 radix-4 Booth multiplier. Six aligned
//               sum/carry rows are reduced to two, registered, then added
//               to form the 32-bit product. Two-stage valid/ready pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_final_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [21:0] s0,
    input  logic [19:0] c0,
    input  logic [21:0] s1,
    input  logic [19:0] c1,
    input  logic [19:0] s2,
    input  logic [17:0] c2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] product
);

    // Rows zero-extended and placed at their binary weight.
    logic [31:0] w_row_s0;
    logic [31:0] w_row_c0;
    logic [31:0] w_row_s1;
    logic [31:0] w_row_c1;
    logic [31:0] w_row_s2;
    logic [31:0] w_row_c2;

    assign w_row_s0 = {10'b0, s0};
    assign w_row_c0 = {9'b0, c0, 3'b0};
    assign w_row_s1 = {4'b0, s1, 6'b0};
    assign w_row_c1 = {3'b0, c1, 9'b0};
    assign w_row_s2 = {s2, 12'b0};
    // c2 MSB lands on bit 32 and falls off the product.
    assign w_row_c2 = {c2[16:0], 15'b0};

    // Level A: two independent 3:2 counters.
    logic [31:0] w_sum_a0, w_maj_a0, w_car_a0;
    logic [31:0] w_sum_a1, w_maj_a1, w_car_a1;

    assign w_sum_a0 = w_row_s0 ^ w_row_c0 ^ w_row_s1;
    assign w_maj_a0 = (w_row_s0 & w_row_c0) | (w_row_s0 & w_row_s1) | (w_row_c0 & w_row_s1);
    assign w_car_a0 = {w_maj_a0[30:0], 1'b0};

    assign w_sum_a1 = w_row_c1 ^ w_row_s2 ^ w_row_c2;
    assign w_maj_a1 = (w_row_c1 & w_row_s2) | (w_row_c1 & w_row_c2) | (w_row_s2 & w_row_c2);
    assign w_car_a1 = {w_maj_a1[30:0], 1'b0};

    // Level B: compress three of the four level-A rows.
    logic [31:0] w_sum_b, w_maj_b, w_car_b;

    assign w_sum_b = w_sum_a0 ^ w_car_a0 ^ w_sum_a1;
    assign w_maj_b = (w_sum_a0 & w_car_a0) | (w_sum_a0 & w_sum_a1) | (w_car_a0 & w_sum_a1);
    assign w_car_b = {w_maj_b[30:0], 1'b0};

    // Level C: fold the leftover level-A carry into the level-B pair.
    logic [31:0] w_sum_c, w_maj_c, w_car_c;

    assign w_sum_c = w_sum_b ^ w_car_b ^ w_car_a1;
    assign w_maj_c = (w_sum_b & w_car_b) | (w_sum_b & w_car_a1) | (w_car_b & w_car_a1);
    assign w_car_c = {w_maj_c[30:0], 1'b0};

    // Bits that carry past weight 2^31 are discarded by the mod-2^32 product.
    logic [4:0] w_unused_msbs;
    assign w_unused_msbs = {c2[17], w_maj_a0[31], w_maj_a1[31], w_maj_b[31], w_maj_c[31]};

    // Pipeline registers and handshake.
    logic        r_v1;
    logic        r_v2;
    logic [31:0] r_sum;
    logic [31:0] r_carry;
    logic [31:0] r_product;
    logic        w_load1;
    logic        w_load2;

    // Stage 2 advances when empty or drained this cycle; stage 1 when empty
    // or when stage 2 takes its item. No skid buffer, so in_ready follows
    // out_ready combinationally when the pipe is full.
    assign w_load2   = !r_v2 || out_ready;
    assign w_load1   = !r_v1 || w_load2;
    assign in_ready  = w_load1;
    assign out_valid = r_v2;
    assign product   = r_product;

    // Stage 1: capture the compressed sum/carry pair on an input transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_sum   <= 32'd0;
            r_carry <= 32'd0;
        end else if (w_load1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_sum   <= w_sum_c;
                r_carry <= w_car_c;
            end
        end
    end

    // Stage 2: carry-propagate add; product holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2      <= 1'b0;
            r_product <= 32'd0;
        end else if (w_load2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_product <= r_sum + r_carry;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_final_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_final_stage
// Description : Self-checking bench for booth_final_stage: directed vector
//               table, latency/backpressure/reset sequences, random stream
//               against a scoreboard of reference sums.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_final_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [21:0] s0;
    logic [19:0] c0;
    logic [21:0] s1;
    logic [19:0] c1;
    logic [19:0] s2;
    logic [17:0] c2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;

    booth_final_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s0        (s0),
        .c0        (c0),
        .s1        (s1),
        .c1        (c1),
        .s2        (s2),
        .c2        (c2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          out_cnt  = 0;
    logic [31:0] cur_exp  = 32'd0;
    logic [31:0] exp_q[$];
    logic        hold_pending = 1'b0;
    logic [31:0] hold_val     = 32'd0;

    typedef struct {
        logic [21:0] s0;
        logic [19:0] c0;
        logic [21:0] s1;
        logic [19:0] c1;
        logic [19:0] s2;
        logic [17:0] c2;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 10;
    vec_t tbl[NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] ref_sum(input logic [21:0] a, input logic [19:0] b,
                                            input logic [21:0] c, input logic [19:0] d,
                                            input logic [19:0] e, input logic [17:0] f);
        logic [63:0] t;
        t = 64'(a) + (64'(b) << 3) + (64'(c) << 6) + (64'(d) << 9)
          + (64'(e) << 12) + (64'(f) << 15);
        return t[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rows(input vec_t v);
        s0 = v.s0; c0 = v.c0; s1 = v.s1; c1 = v.c1; s2 = v.s2; c2 = v.c2;
        cur_exp = v.exp;
    endtask

    task automatic set_s0(input logic [21:0] val);
        s0 = val; c0 = '0; s1 = '0; c1 = '0; s2 = '0; c2 = '0;
        cur_exp = {10'd0, val};
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < bound) begin
            step();
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: values sampled mid-cycle are the ones the next edge sees.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_hold", product, hold_val);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_unexpected actual=%h required=none at %0t", product, $time);
                end else begin
                    chk("stream_product", product, exp_q.pop_front());
                end
                out_cnt++;
            end
            hold_pending = out_valid && !out_ready;
            hold_val     = product;
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
        end
    end

    initial begin : main
        int          k;
        int          accepted;
        int          base;
        int          sent;
        int          cyc;
        logic        acc;
        logic [31:0] r32;

        tbl[0] = '{22'd1,       20'd0,       22'd0,        20'd0,       20'd0,       18'd0,       32'h0000_0001};
        tbl[1] = '{22'd0,       20'd1,       22'd0,        20'd0,       20'd0,       18'd0,       32'h0000_0008};
        tbl[2] = '{22'd0,       20'd0,       22'd1,        20'd0,       20'd0,       18'd0,       32'h0000_0040};
        tbl[3] = '{22'd0,       20'd0,       22'd0,        20'd1,       20'd0,       18'd0,       32'h0000_0200};
        tbl[4] = '{22'd0,       20'd0,       22'd0,        20'd0,       20'd1,       18'd0,       32'h0000_1000};
        tbl[5] = '{22'd0,       20'd0,       22'd0,        20'd0,       20'd0,       18'd1,       32'h0000_8000};
        tbl[6] = '{22'd0,       20'd0,       22'd0,        20'd0,       20'hFFFFF,   18'h3FFFF,   32'hFFFF_7000};
        tbl[7] = '{22'd3,       20'd2,       22'd1,        20'd1,       20'd0,       18'd0,       32'h0000_0253};
        tbl[8] = '{22'd0,       20'd0,       22'h3FFFFF,   20'hFFFFF,   20'd0,       18'd0,       32'h2FFF_FDC0};
        tbl[9] = '{22'd0,       20'd0,       22'd0,        20'd0,       20'd0,       18'h30000,   32'h8000_0000};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_s0(22'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_product",   product,             32'd0);
        chk("reset_in_ready",  {31'd0, in_ready},   32'd1);

        // Single item latency.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_s0(22'd5);
        #1;
        chk("single_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("single_not_yet", {31'd0, out_valid}, 32'd0);
        step();
        chk("single_valid",   {31'd0, out_valid}, 32'd1);
        chk("single_product", product,            32'h0000_0005);
        step();
        chk("single_gone",    {31'd0, out_valid}, 32'd0);

        // Table vectors back to back; output must follow with no bubble.
        for (int i = 0; i < NVEC; i++) begin
            in_valid = 1'b1;
            set_rows(tbl[i]);
            #1;
            chk("tbl_in_ready", {31'd0, in_ready}, 32'd1);
            if (i == 1) chk("tbl_first_latency", {31'd0, out_valid}, 32'd0);
            if (i >= 2) begin
                chk("tbl_valid",   {31'd0, out_valid}, 32'd1);
                chk("tbl_product", product,            tbl[i-2].exp);
            end
            step();
        end
        in_valid = 1'b0;
        chk("tbl_valid",   {31'd0, out_valid}, 32'd1);
        chk("tbl_product", product,            tbl[NVEC-2].exp);
        step();
        chk("tbl_valid",   {31'd0, out_valid}, 32'd1);
        chk("tbl_product", product,            tbl[NVEC-1].exp);
        step();
        chk("tbl_drained", {31'd0, out_valid}, 32'd0);

        // Backpressure: out_ready low for 5 cycles while streaming 1..4.
        base      = out_cnt;
        out_ready = 1'b0;
        k         = 1;
        accepted  = 0;
        cyc       = 0;
        while (k <= 4 && cyc < 30) begin
            if (cyc == 5) out_ready = 1'b1;
            in_valid = 1'b1;
            set_s0(22'(k));
            #1;
            if (cyc >= 2 && cyc <= 4) begin
                chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
                chk("bp_hold_product", product,            32'd1);
            end
            if (cyc == 2) chk("bp_accepts_before_full", 32'(accepted), 32'd2);
            if (cyc == 5) chk("bp_release_accepts", {31'd0, in_ready}, 32'd1);
            acc = in_ready;
            step();
            if (acc) begin
                k++;
                accepted++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        chk("bp_all_sent", 32'(accepted), 32'd4);
        wait_drain("bp_drain", 20);
        chk("bp_out_count", 32'(out_cnt - base), 32'd4);

        // Reset with both stages full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_s0(22'd100);
        step();
        set_s0(22'd101);
        step();
        in_valid = 1'b0;
        #1;
        chk("rst_full_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_product",   product,             32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},   32'd1);
        base      = out_cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("rst_no_stale", 32'(out_cnt - base), 32'd0);

        // Random stream with random valid/ready.
        base = out_cnt;
        sent = 0;
        cyc  = 0;
        acc  = 1'b0;
        in_valid = 1'b0;
        while (sent < 10000 && cyc < 60000) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                r32 = $urandom; s0 = r32[21:0];
                r32 = $urandom; c0 = r32[19:0];
                r32 = $urandom; s1 = r32[21:0];
                r32 = $urandom; c1 = r32[19:0];
                r32 = $urandom; s2 = r32[19:0];
                r32 = $urandom; c2 = r32[17:0];
                cur_exp = ref_sum(s0, c0, s1, c1, s2, c2);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc = in_valid && in_ready;
            step();
            if (acc) sent++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("rand_sent", 32'(sent), 32'd10000);
        wait_drain("rand_drain", 20);
        chk("rand_out_count", 32'(out_cnt - base), 32'd10000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
